// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl
// Sits between E-stage branch resolution and the local predictor's update port.
// Resolved-branch records are queued in a small FIFO and drained one per cycle
// into the BHT/PHT. A mispredict on an accepted record raises a registered
// one-cycle flush with the redirect PC. The controller then ignores wrong-path
// resolutions for SHADOW_CYCLES cycles. It also keeps saturating accuracy counters.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   res_valid / res_ready         resolution handshake (res_ready = FIFO not full)
//   res_bht_index, res_pht_index  predictor indices used at fetch
//   res_predicted, res_taken      predicted and actual direction
//   res_target, res_fallthru      taken target and sequential PC
//   upd_hold                      stall: do not drain this cycle
//   upd_valid, upd_*              registered one-cycle update strobe and head record
//   flush, redirect_pc            mispredict flush pulse and fetch redirect target
//   branch_cnt, mispred_cnt       accepted resolutions / mispredicts (saturating)
//   drop_cnt                      resolutions lost to a full FIFO (saturating)
module bp_update_ctrl #(
  parameter int PHT_INDEX_BITS = 7,
  parameter int BHT_INDEX_BITS = 3,
  parameter int QDEPTH         = 4,
  parameter int SHADOW_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [BHT_INDEX_BITS-1:0] res_bht_index,
  input  logic [PHT_INDEX_BITS-1:0] res_pht_index,
  input  logic                      res_predicted,
  input  logic                      res_taken,
  input  logic [31:0]               res_target,
  input  logic [31:0]               res_fallthru,
  input  logic                      upd_hold,
  output logic                      upd_valid,
  output logic [BHT_INDEX_BITS-1:0] upd_bht_index,
  output logic [PHT_INDEX_BITS-1:0] upd_pht_index,
  output logic                      upd_taken,
  output logic                      flush,
  output logic [31:0]               redirect_pc,
  output logic [31:0]               branch_cnt,
  output logic [31:0]               mispred_cnt,
  output logic [15:0]               drop_cnt
);

  localparam int AW    = $clog2(QDEPTH);
  localparam int PW    = AW + 1;
  localparam int REC_W = BHT_INDEX_BITS + PHT_INDEX_BITS + 1;
  localparam int SW    = $clog2(SHADOW_CYCLES + 1);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SHADOW = 1'b1;

  logic [REC_W-1:0] mem_q [QDEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    shadow_cnt_q, shadow_cnt_d;
  logic             upd_valid_q, upd_valid_d;
  logic [REC_W-1:0] upd_rec_q, upd_rec_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic full, empty, in_run, accept, drop, mispred, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign in_run  = (state_q == ST_RUN);
  assign accept  = res_valid && !full && in_run;
  assign drop    = res_valid && full && in_run;
  assign mispred = accept && (res_predicted != res_taken);
  // Only registered state feeds pop, so a record pushed this cycle drains no earlier than next cycle.
  assign pop     = !empty && !upd_hold;

  always_comb begin
    wr_ptr_d      = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    upd_valid_d   = pop;
    upd_rec_d     = pop ? mem_q[rd_ptr_q[AW-1:0]] : upd_rec_q;
    flush_d       = mispred;
    redirect_d    = mispred ? (res_taken ? res_target : res_fallthru) : 32'h0;
    branch_cnt_d  = (accept && !(&branch_cnt_q)) ? branch_cnt_q + 1'b1 : branch_cnt_q;
    mispred_cnt_d = (mispred && !(&mispred_cnt_q)) ? mispred_cnt_q + 1'b1 : mispred_cnt_q;
    drop_cnt_d    = (drop && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;

    state_d      = state_q;
    shadow_cnt_d = shadow_cnt_q;
    if (in_run) begin
      if (mispred) begin
        state_d      = ST_SHADOW;
        shadow_cnt_d = SW'(SHADOW_CYCLES);
      end
    end else begin
      // The flush cycle is the first shadow cycle; return to RUN once the count runs out.
      if (shadow_cnt_q <= SW'(1)) begin
        state_d      = ST_RUN;
        shadow_cnt_d = '0;
      end else begin
        shadow_cnt_d = shadow_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {res_bht_index, res_pht_index, res_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      state_q       <= ST_RUN;
      shadow_cnt_q  <= '0;
      upd_valid_q   <= 1'b0;
      upd_rec_q     <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      state_q       <= state_d;
      shadow_cnt_q  <= shadow_cnt_d;
      upd_valid_q   <= upd_valid_d;
      upd_rec_q     <= upd_rec_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign res_ready     = !full;
  assign upd_valid     = upd_valid_q;
  assign upd_bht_index = upd_rec_q[REC_W-1 -: BHT_INDEX_BITS];
  assign upd_pht_index = upd_rec_q[PHT_INDEX_BITS:1];
  assign upd_taken     = upd_rec_q[0];
  assign flush         = flush_q;
  assign redirect_pc   = redirect_q;
  assign branch_cnt    = branch_cnt_q;
  assign mispred_cnt   = mispred_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
